// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
//   Sequencing controller for an unsigned arithmetic datapath. It accepts one
//   operation at a time over a valid/ready request port. It then executes the
//   operation and returns a registered result over a valid/ready response port.
//   Add, sub, mul and square take one execute cycle. Div and mod run a
//   restoring divider that produces one quotient bit per cycle, MSB first.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   request valid
//   in_ready   high only in IDLE; a request is accepted on in_valid & in_ready
//   op         0=add 1=sub 2=mul 3=div 4=mod 5=square 6/7=illegal
//   in1, in2   unsigned operands, latched at the accept edge
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   result     2*WIDTH-bit result, held stable while out_valid & !out_ready
//   err        divide/modulo by zero or illegal op, qualified by out_valid
//   busy       high in EXEC and DONE
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               err,
  output logic               busy
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_SQR = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    result_q, result_d;
  logic             err_q, err_d;

  // Datapath temporaries
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [RW-1:0]    prod_w;
  logic [RW-1:0]    sqr_w;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;

    sum_w  = {1'b0, a_q} + {1'b0, b_q};
    // A (WIDTH+1)-bit wrap gives the two's-complement difference mod 2^(WIDTH+1).
    diff_w = {1'b0, a_q} - {1'b0, b_q};
    prod_w = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    sqr_w  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, a_q};

    // One restoring step: shift in the next dividend bit and trial-subtract.
    // The shifted remainder is below 2*divisor, so a set MSB on the trial
    // means it borrowed and the remainder is kept unchanged.
    rem_sh = {rem_q, a_q[cnt_q]};
    trial  = rem_sh - {1'b0, b_q};
    if (trial[WIDTH]) begin
      rem_n = rem_sh[WIDTH-1:0];
      quo_n = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_n = trial[WIDTH-1:0];
      quo_n = {quo_q[WIDTH-2:0], 1'b1};
    end

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          a_d     = in1;
          b_d     = in2;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        unique case (op_q)
          OP_ADD: begin
            result_d = {{(WIDTH-1){1'b0}}, sum_w};
            err_d    = 1'b0;
            state_d  = S_DONE;
          end
          OP_SUB: begin
            result_d = {{(WIDTH-1){1'b0}}, diff_w};
            err_d    = 1'b0;
            state_d  = S_DONE;
          end
          OP_MUL: begin
            result_d = prod_w;
            err_d    = 1'b0;
            state_d  = S_DONE;
          end
          OP_SQR: begin
            result_d = sqr_w;
            err_d    = 1'b0;
            state_d  = S_DONE;
          end
          OP_DIV, OP_MOD: begin
            if (b_q == '0) begin
              // A zero divisor finishes at once with a fixed result.
              err_d    = 1'b1;
              result_d = (op_q == OP_DIV) ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                          : {{WIDTH{1'b0}}, a_q};
              state_d  = S_DONE;
            end else begin
              rem_d = rem_n;
              quo_d = quo_n;
              cnt_d = cnt_q - CW'(1);
              if (cnt_q == '0) begin
                result_d = (op_q == OP_DIV) ? {{WIDTH{1'b0}}, quo_n}
                                            : {{WIDTH{1'b0}}, rem_n};
                err_d    = 1'b0;
                state_d  = S_DONE;
              end
            end
          end
          default: begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = S_DONE;
          end
        endcase
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
//   Directed bench for alu_seq_ctrl. A transaction-level model predicts the
//   handshake levels and the result of each accepted request. One compare
//   process checks the DUT against the model on every falling edge. The
//   stimulus tasks also pin each transaction to hand-computed literals:
//   result, err and latency.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic [W-1:0]   in1;
  logic [W-1:0]   in2;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           err;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: the outcome of one request, computed directly from the operation.
  // ---------------------------------------------------------------------------
  function automatic void predict(input logic [2:0] o, input int a, input int b,
                                  output int res, output bit e, output int lat);
    e   = 1'b0;
    lat = 1;
    case (o)
      3'd0: res = a + b;
      3'd1: res = (a - b + 512) % 512;
      3'd2: res = a * b;
      3'd3: if (b == 0) begin res = 255; e = 1'b1; end else begin res = a / b; lat = W; end
      3'd4: if (b == 0) begin res = a;   e = 1'b1; end else begin res = a % b; lat = W; end
      3'd5: res = a * a;
      default: begin res = 0; e = 1'b1; end
    endcase
  endfunction

  bit          m_busy, m_done, m_err;
  int          m_left;
  logic [15:0] m_res;
  int          p_res, p_lat;
  bit          p_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_err  = 1'b0;
      m_left = 0;
      m_res  = '0;
    end else if (!m_busy) begin
      if (in_valid === 1'b1) begin
        predict(op, int'(in1), int'(in2), p_res, p_err, p_lat);
        m_res  = p_res[15:0];
        m_err  = p_err;
        m_left = p_lat;
        m_busy = 1'b1;
      end
    end else if (!m_done) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (out_ready === 1'b1) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model in_ready",  in_ready,  !m_busy);
      check("model busy",      busy,      m_busy);
      check("model out_valid", out_valid, m_done);
      if (m_done) begin
        check("model result", result, m_res);
        check("model err",    err,    m_err);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One complete transaction, with literal expectations.
  // ---------------------------------------------------------------------------
  task automatic run_op(input string name, input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_res, input bit exp_err,
                        input int exp_lat, input int hold, input bit early_rdy);
    int lat;
    @(negedge clk);
    in_valid  = 1'b1;
    op        = o;
    in1       = a;
    in2       = b;
    out_ready = early_rdy;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op       = 3'($urandom_range(0, 7));
    in1      = 8'($urandom);
    in2      = 8'($urandom);
    check({name, " in_ready low"}, in_ready, 0);
    check({name, " busy high"},    busy,     1);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (out_valid !== 1'b1 && lat < 40);
    check({name, " latency"}, lat,     exp_lat);
    check({name, " result"},  result,  exp_res);
    check({name, " err"},     err,     exp_err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, " hold out_valid"}, out_valid, 1);
      check({name, " hold result"},    result,    exp_res);
      check({name, " hold in_ready"},  in_ready,  0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " idle in_ready"},  in_ready,  1);
    check({name, " idle out_valid"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ov_seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    in1       = '0;
    in2       = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset in_ready",  in_ready,  1);
    check("reset busy",      busy,      0);
    check("reset out_valid", out_valid, 0);
    check("reset result",    result,    0);
    check("reset err",       err,       0);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    //      name        op    a       b       result     err lat hold early
    run_op("add",       3'd0, 8'd200, 8'd100, 16'h012C, 0, 1, 0, 0);
    run_op("sub",       3'd1, 8'd5,   8'd10,  16'h01FB, 0, 1, 0, 0);
    run_op("mul",       3'd2, 8'd255, 8'd255, 16'hFE01, 0, 1, 0, 0);
    run_op("square",    3'd5, 8'd16,  8'd77,  16'h0100, 0, 1, 0, 0);
    run_op("div",       3'd3, 8'd200, 8'd7,   16'h001C, 0, 8, 0, 0);
    run_op("mod",       3'd4, 8'd200, 8'd7,   16'h0004, 0, 8, 0, 0);
    run_op("div0",      3'd3, 8'd9,   8'd0,   16'h00FF, 1, 1, 0, 0);
    run_op("mod0",      3'd4, 8'd9,   8'd0,   16'h0009, 1, 1, 0, 0);
    run_op("illegal7",  3'd7, 8'd9,   8'd3,   16'h0000, 1, 1, 0, 0);
    run_op("illegal6",  3'd6, 8'd42,  8'd17,  16'h0000, 1, 1, 0, 1);
    run_op("addmax",    3'd0, 8'd255, 8'd255, 16'h01FE, 0, 1, 0, 1);
    run_op("subwrap",   3'd1, 8'd0,   8'd255, 16'h0101, 0, 1, 0, 0);
    run_op("div_by1",   3'd3, 8'd255, 8'd1,   16'h00FF, 0, 8, 0, 1);
    run_op("div_small", 3'd3, 8'd13,  8'd255, 16'h0000, 0, 8, 0, 0);
    run_op("mod_small", 3'd4, 8'd13,  8'd255, 16'h000D, 0, 8, 0, 0);
    run_op("backpress", 3'd2, 8'd3,   8'd4,   16'h000C, 0, 1, 5, 0);

    // Asynchronous reset in the fourth cycle of a division.
    @(negedge clk);
    in_valid  = 1'b1;
    op        = 3'd3;
    in1       = 8'd200;
    in2       = 8'd7;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst in_ready",  in_ready,  1);
    check("midrst busy",      busy,      0);
    check("midrst out_valid", out_valid, 0);
    check("midrst result",    result,    0);
    check("midrst err",       err,       0);
    @(posedge clk);
    #2 rst = 1'b0;
    ov_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) ov_seen = 1'b1;
    end
    check("midrst no out_valid", ov_seen, 0);
    out_ready = 1'b0;

    run_op("add_after_rst", 3'd0, 8'd1, 8'd1, 16'h0002, 0, 1, 0, 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
